seq_shift_subtract_divider: RTL



---
 rtl/seq_shift_subtract_divider_if.sv | 25 ++
 rtl/seq_shift_subtract_divider.sv | 110 +++++++++++
 2 files changed

// File: rtl/seq_shift_subtract_divider_if.sv
// Start/done handshake bundle between a controller (master) and the
// sequential divider (slave).
interface seq_shift_subtract_divider_if #(
    parameter int DW = 8,
    parameter int VW = 4
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_shift_subtract_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock.
// Optional macro DIV_BY_2_FAST_EN: divisor==2 resolves in one cycle.
module seq_shift_subtract_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    seq_shift_subtract_divider_if.slave      bus
);
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [VW-1:0] p_q, p_d;
    logic [DW-1:0] q_q, q_d;
    logic [VW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          dbz_q, dbz_d;

    logic [VW:0]   p_shift;
    logic          fits;

    // The partial remainder stays below the divisor, so VW bits suffice between
    // iterations; only the shifted value needs the extra bit for the compare.
    assign p_shift = {p_q, q_q[DW-1]};
    assign fits    = (p_shift >= {1'b0, div_q});

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    div_d = bus.divisor;
                    dbz_d = 1'b0;
                    if (bus.divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
`ifdef DIV_BY_2_FAST_EN
                    else if ((VW >= 2) && (bus.divisor == VW'(2))) begin
                        quot_d  = bus.dividend >> 1;
                        rem_d   = VW'(bus.dividend[0]);
                        state_d = DONE;
                    end
`endif
                    else begin
                        p_d     = '0;
                        q_d     = bus.dividend;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                p_d   = fits ? (p_shift[VW-1:0] - div_q) : p_shift[VW-1:0];
                q_d   = {q_q[DW-2:0], fits};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DW - 1)) begin
                    quot_d  = q_d;
                    rem_d   = p_d;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule
